// File: rtl/control_clave.sv
// Passcode sequencer: buffers up to four keypad digits, checks them on '#',
// pulses grant on a match and enters a timed alarm lockout after repeated failures.
module control_clave #(
  parameter logic [15:0] CODE           = 16'h4693,
  parameter int unsigned MAX_TRIES      = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [31:0] LOCK_CYCLES    = 32'd1_500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       grant,
  output logic       alarm,
  output logic       locked,
  output logic [2:0] count,
  output logic [1:0] tries,
  output logic [1:0] mns
);

  // IDLE wait presence | ENTRY collect keys | CHECK compare | GRANT open pulse | DENY count failure | LOCKOUT alarm
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT} state_t;

  localparam logic [2:0]  MAX_T    = 3'(MAX_TRIES);
  localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] LCK_LAST = LOCK_CYCLES - 32'd1;

  localparam logic [1:0] MSG_PROMPT = 2'b00;
  localparam logic [1:0] MSG_WRONG  = 2'b01;
  localparam logic [1:0] MSG_OPEN   = 2'b10;
  localparam logic [1:0] MSG_ALARM  = 2'b11;

  state_t      state, state_n;
  logic [15:0] buffer, buffer_n;
  logic [2:0]  count_n;
  logic [1:0]  tries_n, mns_n;
  logic [31:0] timer, timer_n;
  logic [2:0]  tries_inc;
  logic        is_digit;

  assign is_digit  = (key <= 4'd9);
  assign tries_inc = {1'b0, tries} + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      buffer <= '0;
      count  <= '0;
      tries  <= '0;
      mns    <= MSG_PROMPT;
      timer  <= '0;
    end else begin
      state  <= state_n;
      buffer <= buffer_n;
      count  <= count_n;
      tries  <= tries_n;
      mns    <= mns_n;
      timer  <= timer_n;
    end
  end

  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    count_n  = count;
    tries_n  = tries;
    mns_n    = mns;
    timer_n  = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n  = ENTRY;
          buffer_n = '0;
          count_n  = '0;
          mns_n    = MSG_PROMPT;
        end
      end
      ENTRY: begin
        if (!enable) begin
          state_n  = IDLE;
          buffer_n = '0;
          count_n  = '0;
        end else if (key_valid) begin
          // every strobe, even an ignored code, restarts the inactivity timer
          if (is_digit) begin
            mns_n = MSG_PROMPT;
            if (count < 3'd4) begin
              buffer_n = {buffer[11:0], key};
              count_n  = count + 3'd1;
            end
          end else if (key == 4'hE) begin
            buffer_n = '0;
            count_n  = '0;
            mns_n    = MSG_PROMPT;
          end else if (key == 4'hF) begin
            state_n = (count == 3'd4) ? CHECK : DENY;
          end
        end else if (timer == TO_LAST) begin
          state_n  = IDLE;
          buffer_n = '0;
          count_n  = '0;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      CHECK: state_n = (buffer == CODE) ? GRANT : DENY;
      GRANT: begin
        state_n  = IDLE;
        tries_n  = '0;
        mns_n    = MSG_OPEN;
        buffer_n = '0;
        count_n  = '0;
      end
      DENY: begin
        tries_n  = tries_inc[1:0];
        buffer_n = '0;
        count_n  = '0;
        // the alarm message must already be showing on the first lockout cycle
        if (tries_inc == MAX_T) begin
          state_n = LOCKOUT;
          mns_n   = MSG_ALARM;
        end else begin
          state_n = ENTRY;
          mns_n   = MSG_WRONG;
        end
      end
      LOCKOUT: begin
        if (timer == LCK_LAST) begin
          state_n = IDLE;
          tries_n = '0;
          mns_n   = MSG_PROMPT;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant  = (state == GRANT);
  assign alarm  = (state == LOCKOUT);
  assign locked = (state == LOCKOUT);

endmodule

// File: tb/tb_control_clave.sv
// Directed bench for control_clave with short timeout (50) and lockout (20) windows.
module tb_control_clave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic       grant, alarm, locked;
  logic [2:0] count;
  logic [1:0] tries, mns;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_GRANT = 3'd3;
  localparam logic [2:0] S_DENY  = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;

  logic [3:0] good [4];
  logic [3:0] lock_seq [5];
  logic [2:0] st;

  control_clave #(
    .TIMEOUT_CYCLES(32'd50),
    .LOCK_CYCLES   (32'd20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .key_valid(key_valid),
    .key      (key),
    .grant    (grant),
    .alarm    (alarm),
    .locked   (locked),
    .count    (count),
    .tries    (tries),
    .mns      (mns)
  );

  always #5 clk = ~clk;
  assign st = dut.state;

  // key is sampled by the posedge between the two negedges; returns just after that edge
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({grant, alarm, locked} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {grant, alarm, locked}); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if ({tries, mns} !== 4'b0000) begin n_err++; $display("FAIL reset_tries_mns: got %b want 0000", {tries, mns}); end
    n_cmp++; if (st !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", st, S_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_correct();
    @(negedge clk);
    n_cmp++; if (st !== S_ENTRY) begin n_err++; $display("FAIL correct_enter: got %0d want %0d", st, S_ENTRY); end
    for (int i = 0; i < 4; i++) begin
      press(good[i]);
      n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL correct_count%0d: got %0d want %0d", i, count, i + 1); end
    end
    press(4'hF);
    n_cmp++; if (st !== S_CHECK || grant !== 1'b0) begin n_err++; $display("FAIL correct_check: state %0d grant %b want %0d 0", st, grant, S_CHECK); end
    @(negedge clk);
    n_cmp++; if (grant !== 1'b1 || st !== S_GRANT) begin n_err++; $display("FAIL correct_grant: grant %b state %0d want 1 %0d", grant, st, S_GRANT); end
    @(negedge clk);
    n_cmp++; if (grant !== 1'b0) begin n_err++; $display("FAIL correct_grant_width: got %b want 0", grant); end
    n_cmp++; if (mns !== 2'b10 || tries !== 2'd0) begin n_err++; $display("FAIL correct_msg: mns %b tries %0d want 10 0", mns, tries); end
    n_cmp++; if (st !== S_IDLE || count !== 3'd0) begin n_err++; $display("FAIL correct_idle: state %0d count %0d want %0d 0", st, count, S_IDLE); end
  endtask

  task automatic test_wrong_recover();
    for (int i = 0; i < 4; i++) press(4'(i + 1));
    press(4'hF);
    n_cmp++; if (st !== S_CHECK) begin n_err++; $display("FAIL wrong_check: got %0d want %0d", st, S_CHECK); end
    @(negedge clk);
    n_cmp++; if (st !== S_DENY || grant !== 1'b0) begin n_err++; $display("FAIL wrong_deny: state %0d grant %b want %0d 0", st, grant, S_DENY); end
    @(negedge clk);
    n_cmp++; if (mns !== 2'b01 || tries !== 2'd1) begin n_err++; $display("FAIL wrong_msg: mns %b tries %0d want 01 1", mns, tries); end
    n_cmp++; if (count !== 3'd0 || st !== S_ENTRY || grant !== 1'b0) begin n_err++; $display("FAIL wrong_after: count %0d state %0d grant %b want 0 %0d 0", count, st, grant, S_ENTRY); end
    for (int i = 0; i < 4; i++) press(good[i]);
    press(4'hF);
    @(negedge clk);
    n_cmp++; if (grant !== 1'b1) begin n_err++; $display("FAIL recover_grant: got %b want 1", grant); end
    @(negedge clk);
    n_cmp++; if (tries !== 2'd0 || mns !== 2'b10) begin n_err++; $display("FAIL recover_tries: tries %0d mns %b want 0 10", tries, mns); end
  endtask

  task automatic test_short_overflow_clear();
    press(4'h4);
    press(4'h6);
    press(4'hF);
    n_cmp++; if (st !== S_DENY) begin n_err++; $display("FAIL short_deny: got %0d want %0d", st, S_DENY); end
    @(negedge clk);
    n_cmp++; if (tries !== 2'd1 || mns !== 2'b01 || count !== 3'd0) begin n_err++; $display("FAIL short_after: tries %0d mns %b count %0d want 1 01 0", tries, mns, count); end
    for (int i = 0; i < 4; i++) begin
      press(good[i]);
      if (i == 0) begin
        n_cmp++; if (mns !== 2'b00) begin n_err++; $display("FAIL digit_prompt: got %b want 00", mns); end
      end
    end
    press(4'h7);
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL overflow_count: got %0d want 4", count); end
    press(4'hE);
    n_cmp++; if (count !== 3'd0 || mns !== 2'b00) begin n_err++; $display("FAIL clear: count %0d mns %b want 0 00", count, mns); end
    for (int i = 0; i < 4; i++) press(good[i]);
    press(4'hF);
    @(negedge clk);
    n_cmp++; if (grant !== 1'b1) begin n_err++; $display("FAIL clear_grant: got %b want 1", grant); end
    @(negedge clk);
    n_cmp++; if (tries !== 2'd0) begin n_err++; $display("FAIL clear_tries: got %0d want 0", tries); end
    // fifth digit must leave the buffered code untouched
    for (int i = 0; i < 4; i++) press(good[i]);
    press(4'h7);
    press(4'hF);
    @(negedge clk);
    n_cmp++; if (grant !== 1'b1) begin n_err++; $display("FAIL overflow_grant: got %b want 1", grant); end
    @(negedge clk);
  endtask

  task automatic test_lockout();
    int   hi_cnt, full_cnt;
    logic first_hi, grant_seen, dropped;
    hi_cnt = 0; full_cnt = 0; first_hi = 1'b0; grant_seen = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 4; i++) press(4'h1);
    press(4'hF);
    @(negedge clk);
    @(negedge clk);
    press(4'hF);
    press(4'hF);
    n_cmp++; if (st !== S_DENY || tries !== 2'd2) begin n_err++; $display("FAIL lock_third_deny: state %0d tries %0d want %0d 2", st, tries, S_DENY); end
    for (int i = 0; i < 40 && !dropped; i++) begin
      @(negedge clk);
      if (i == 0) first_hi = alarm;
      if (grant) grant_seen = 1'b1;
      if (alarm) begin
        hi_cnt++;
        if (locked && mns == 2'b11) full_cnt++;
      end else begin
        dropped = 1'b1;
      end
      key_valid = (i < 10) && (i % 2 == 0);
      key = (i < 10) ? lock_seq[i / 2] : 4'h0;
    end
    key_valid = 1'b0;
    n_cmp++; if (first_hi !== 1'b1) begin n_err++; $display("FAIL lock_rise: got %b want 1", first_hi); end
    n_cmp++; if (hi_cnt != 20) begin n_err++; $display("FAIL lock_len: got %0d want 20", hi_cnt); end
    n_cmp++; if (full_cnt != 20) begin n_err++; $display("FAIL lock_outputs: got %0d want 20", full_cnt); end
    n_cmp++; if (grant_seen !== 1'b0) begin n_err++; $display("FAIL lock_no_grant: got %b want 0", grant_seen); end
    n_cmp++; if (st !== S_IDLE || tries !== 2'd0 || mns !== 2'b00) begin n_err++; $display("FAIL lock_exit: state %0d tries %0d mns %b want %0d 0 00", st, tries, mns, S_IDLE); end
    n_cmp++; if (count !== 3'd0 || locked !== 1'b0) begin n_err++; $display("FAIL lock_keys_ignored: count %0d locked %b want 0 0", count, locked); end
  endtask

  task automatic test_timeout_presence();
    press(4'hF);
    @(negedge clk);
    n_cmp++; if (tries !== 2'd1) begin n_err++; $display("FAIL to_setup: got %0d want 1", tries); end
    press(4'h4);
    press(4'h6);
    repeat (49) @(negedge clk);
    n_cmp++; if (st !== S_ENTRY || count !== 3'd2) begin n_err++; $display("FAIL to_hold49: state %0d count %0d want %0d 2", st, count, S_ENTRY); end
    key = 4'h9;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    n_cmp++; if (st !== S_ENTRY || count !== 3'd3) begin n_err++; $display("FAIL to_key_wins: state %0d count %0d want %0d 3", st, count, S_ENTRY); end
    repeat (49) @(negedge clk);
    n_cmp++; if (st !== S_ENTRY) begin n_err++; $display("FAIL to_before: got %0d want %0d", st, S_ENTRY); end
    @(negedge clk);
    n_cmp++; if (st !== S_IDLE || count !== 3'd0 || tries !== 2'd1) begin n_err++; $display("FAIL to_expire: state %0d count %0d tries %0d want %0d 0 1", st, count, tries, S_IDLE); end
    press(4'h4);
    press(4'h6);
    press(4'h9);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pres_count: got %0d want 3", count); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (st !== S_IDLE || count !== 3'd0 || tries !== 2'd1) begin n_err++; $display("FAIL pres_loss: state %0d count %0d tries %0d want %0d 0 1", st, count, tries, S_IDLE); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    logic grant_seen;
    grant_seen = 1'b0;
    press(4'h4);
    press(4'h6);
    press(4'h9);
    n_cmp++; if (count !== 3'd3 || tries !== 2'd1) begin n_err++; $display("FAIL ar_setup: count %0d tries %0d want 3 1", count, tries); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0 || tries !== 2'd0 || st !== S_IDLE) begin n_err++; $display("FAIL ar_entry: count %0d tries %0d state %0d want 0 0 %0d", count, tries, st, S_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    press(4'hF);
    press(4'hF);
    press(4'hF);
    repeat (5) @(negedge clk);
    n_cmp++; if (alarm !== 1'b1 || tries !== 2'd3) begin n_err++; $display("FAIL ar_lock_setup: alarm %b tries %0d want 1 3", alarm, tries); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({grant, alarm, locked} !== 3'b000 || mns !== 2'b00 || tries !== 2'd0) begin n_err++; $display("FAIL ar_lock: flags %b mns %b tries %0d want 000 00 0", {grant, alarm, locked}, mns, tries); end
    n_cmp++; if (st !== S_IDLE) begin n_err++; $display("FAIL ar_lock_state: got %0d want %0d", st, S_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (grant) grant_seen = 1'b1;
    end
    n_cmp++; if (grant_seen !== 1'b0 || alarm !== 1'b0) begin n_err++; $display("FAIL ar_after: grant_seen %b alarm %b want 0 0", grant_seen, alarm); end
  endtask

  initial begin
    good[0] = 4'h4; good[1] = 4'h6; good[2] = 4'h9; good[3] = 4'h3;
    lock_seq[0] = 4'h4; lock_seq[1] = 4'h6; lock_seq[2] = 4'h9; lock_seq[3] = 4'h3; lock_seq[4] = 4'hF;
    test_reset();
    test_correct();
    test_wrong_recover();
    test_short_overflow_clear();
    test_lockout();
    test_timeout_presence();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
